// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : MIPS memory-access stage with internal data memory, sub-word
//             load/store, alignment checking and programmable wait states.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        regWrite,
  input  logic        memToReg,
  input  logic [1:0]  size,
  input  logic        loadUnsigned,
  input  logic [31:0] aluResult,
  input  logic [31:0] writeData,
  input  logic [4:0]  writeReg,
  output logic        out_regWrite,
  output logic        out_memToReg,
  output logic [31:0] out_aluResult,
  output logic [31:0] out_readData,
  output logic [4:0]  out_writeReg,
  output logic        stall,
  output logic        misaligned
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [c_CW-1:0] c_CNT_INIT = (LATENCY > 0) ? c_CW'(LATENCY - 1) : '0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            r_state, w_state_next;
  logic [c_CW-1:0]   r_cnt, w_cnt_next;
  logic              w_stall, w_done, w_access, w_misaligned;
  logic [31:0]       r_mem [DEPTH];
  logic [c_AW-1:0]   w_idx;
  logic [31:0]       w_word, w_ext, w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [3:0]        w_be;
  logic              w_unused;

  assign w_misaligned = ((size == 2'b01) && aluResult[0]) ||
                        (size[1] && (aluResult[1:0] != 2'b00));
  assign w_access     = (memRead || memWrite) && !w_misaligned;
  assign w_idx        = aluResult[c_AW+1:2];
  assign w_word       = r_mem[w_idx];
  assign w_unused     = ^aluResult[31:c_AW+2];

  // Read path: little-endian lane select, then extend.
  always_comb begin
    w_byte = w_word[7:0];
    case (aluResult[1:0])
      2'b01:   w_byte = w_word[15:8];
      2'b10:   w_byte = w_word[23:16];
      2'b11:   w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
    w_half = aluResult[1] ? w_word[31:16] : w_word[15:0];
    case (size)
      2'b00:   w_ext = {{24{w_byte[7] & ~loadUnsigned}}, w_byte};
      2'b01:   w_ext = {{16{w_half[15] & ~loadUnsigned}}, w_half};
      default: w_ext = w_word;
    endcase
  end

  // Store lanes: replicate the right-aligned data so every lane sees it.
  always_comb begin
    case (size)
      2'b00: begin
        w_be    = 4'b0001 << aluResult[1:0];
        w_wdata = {4{writeData[7:0]}};
      end
      2'b01: begin
        w_be    = aluResult[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{writeData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = writeData;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_stall      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (LATENCY == 0) begin
            w_done = 1'b1;
          end else begin
            w_stall      = 1'b1;
            w_cnt_next   = c_CNT_INIT;
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) begin
          w_stall    = 1'b1;
          w_cnt_next = r_cnt - 1'b1;
        end else begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Memory is deliberately not reset; reset only drops the pending store.
  always_ff @(posedge clk) begin
    if (w_done && memWrite && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign stall         = w_stall & ~reset;
  assign misaligned    = w_misaligned;
  assign out_regWrite  = regWrite & ~stall & ~reset;
  assign out_memToReg  = memToReg;
  assign out_aluResult = aluResult;
  assign out_writeReg  = writeReg;
  assign out_readData  = (memRead && !w_misaligned) ? w_ext : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : directed self-checking bench for mem_stage at LATENCY 2/3/0.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic [2:0]  rst_v = 3'b111;
  logic        memRead = 0, memWrite = 0, regWrite = 0, memToReg = 0, loadUnsigned = 0;
  logic [1:0]  size = 2'b10;
  logic [31:0] aluResult = 0, writeData = 0;
  logic [4:0]  writeReg = 0;

  logic [2:0]  stall_v, rw_v, m2r_v, mis_v;
  logic [31:0] alu_v [3];
  logic [31:0] rd_v  [3];
  logic [4:0]  wr_v  [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(256), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(rst_v[0]), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .memToReg(memToReg), .size(size), .loadUnsigned(loadUnsigned),
    .aluResult(aluResult), .writeData(writeData), .writeReg(writeReg),
    .out_regWrite(rw_v[0]), .out_memToReg(m2r_v[0]), .out_aluResult(alu_v[0]),
    .out_readData(rd_v[0]), .out_writeReg(wr_v[0]), .stall(stall_v[0]), .misaligned(mis_v[0]));

  mem_stage #(.DEPTH(256), .LATENCY(3)) u_lat3 (
    .clk(clk), .reset(rst_v[1]), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .memToReg(memToReg), .size(size), .loadUnsigned(loadUnsigned),
    .aluResult(aluResult), .writeData(writeData), .writeReg(writeReg),
    .out_regWrite(rw_v[1]), .out_memToReg(m2r_v[1]), .out_aluResult(alu_v[1]),
    .out_readData(rd_v[1]), .out_writeReg(wr_v[1]), .stall(stall_v[1]), .misaligned(mis_v[1]));

  mem_stage #(.DEPTH(256), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(rst_v[2]), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .memToReg(memToReg), .size(size), .loadUnsigned(loadUnsigned),
    .aluResult(aluResult), .writeData(writeData), .writeReg(writeReg),
    .out_regWrite(rw_v[2]), .out_memToReg(m2r_v[2]), .out_aluResult(alu_v[2]),
    .out_readData(rd_v[2]), .out_writeReg(wr_v[2]), .stall(stall_v[2]), .misaligned(mis_v[2]));

  task automatic idle_inputs();
    memRead = 0; memWrite = 0; regWrite = 0; memToReg = 0;
    size = 2'b10; loadUnsigned = 0;
  endtask

  // Runs one access on instance sel and reports what it saw; starts at posedge+1.
  task automatic do_access(input int sel, input bit rd, input bit wr, input logic [1:0] sz,
                           input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                           output int nstall, output logic [31:0] rdata,
                           output bit rw_bad, output logic rw_done, output bit timeout);
    nstall = 0; rw_bad = 0; timeout = 1; rdata = 'x; rw_done = 1'bx;
    memRead = rd; memWrite = wr; regWrite = rd; memToReg = rd;
    size = sz; loadUnsigned = uns; aluResult = addr; writeData = wd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall_v[sel]) begin
        nstall++;
        if (rw_v[sel]) rw_bad = 1;
        @(posedge clk); #1;
      end else begin
        rdata = rd_v[sel]; rw_done = rw_v[sel]; timeout = 0;
        @(posedge clk); #1;
        break;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    memRead = 1; regWrite = 1; aluResult = 32'h10; writeReg = 5'd3;
    #1;
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if (stall_v[s] !== 1'b0) begin n_bad++; $display("FAIL reset_stall[%0d] got %b want 0", s, stall_v[s]); end
      n_cmp++;
      if (rw_v[s] !== 1'b0) begin n_bad++; $display("FAIL reset_regwrite[%0d] got %b want 0", s, rw_v[s]); end
    end
    memRead = 0; #1;
    n_cmp++;
    if (rd_v[0] !== 32'h0) begin n_bad++; $display("FAIL reset_readdata got %h want 0", rd_v[0]); end
    n_cmp++;
    if (alu_v[0] !== 32'h10 || wr_v[0] !== 5'd3) begin
      n_bad++; $display("FAIL reset_passthru got %h/%0d want 10/3", alu_v[0], wr_v[0]);
    end
    idle_inputs();
    @(posedge clk); #1;
    rst_v = 3'b110;
    @(posedge clk); #1;
  endtask

  task automatic test_word_store_load();
    int ns; logic [31:0] rd; bit bad, to; logic rwd;
    do_access(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, ns, rd, bad, rwd, to);
    n_cmp++;
    if (to || ns != 2) begin n_bad++; $display("FAIL word_store_stall got %0d (timeout %0d) want 2", ns, to); end
    do_access(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, ns, rd, bad, rwd, to);
    n_cmp++;
    if (to || ns != 2) begin n_bad++; $display("FAIL word_load_stall got %0d (timeout %0d) want 2", ns, to); end
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_load_data got %h want deadbeef", rd); end
    n_cmp++;
    if (bad || rwd !== 1'b1) begin n_bad++; $display("FAIL word_load_bubble got stalled_rw %0d done_rw %b want 0/1", bad, rwd); end
  endtask

  task automatic test_subword();
    int ns; logic [31:0] rd; bit bad, to; logic rwd;
    do_access(0, 0, 1, 2'b10, 0, 32'h20, 32'h8077F0A1, ns, rd, bad, rwd, to);
    do_access(0, 1, 0, 2'b00, 0, 32'h20, 32'h0, ns, rd, bad, rwd, to);
    n_cmp++;
    if (rd !== 32'hFFFFFFA1) begin n_bad++; $display("FAIL lb_signed got %h want ffffffa1", rd); end
    do_access(0, 1, 0, 2'b00, 1, 32'h23, 32'h0, ns, rd, bad, rwd, to);
    n_cmp++;
    if (rd !== 32'h00000080) begin n_bad++; $display("FAIL lbu got %h want 00000080", rd); end
    do_access(0, 1, 0, 2'b01, 0, 32'h22, 32'h0, ns, rd, bad, rwd, to);
    n_cmp++;
    if (rd !== 32'hFFFF8077) begin n_bad++; $display("FAIL lh_signed got %h want ffff8077", rd); end
    do_access(0, 1, 0, 2'b01, 1, 32'h20, 32'h0, ns, rd, bad, rwd, to);
    n_cmp++;
    if (rd !== 32'h0000F0A1) begin n_bad++; $display("FAIL lhu got %h want 0000f0a1", rd); end
  endtask

  task automatic test_byte_store();
    int ns; logic [31:0] rd; bit bad, to; logic rwd;
    do_access(0, 0, 1, 2'b10, 0, 32'h20, 32'h11223344, ns, rd, bad, rwd, to);
    do_access(0, 0, 1, 2'b00, 0, 32'h21, 32'hFFFFFF5A, ns, rd, bad, rwd, to);
    do_access(0, 1, 0, 2'b10, 0, 32'h20, 32'h0, ns, rd, bad, rwd, to);
    n_cmp++;
    if (rd !== 32'h11225A44) begin n_bad++; $display("FAIL sb_lane got %h want 11225a44", rd); end
    do_access(0, 0, 1, 2'b01, 0, 32'h22, 32'hABCD9876, ns, rd, bad, rwd, to);
    do_access(0, 1, 0, 2'b10, 0, 32'h20, 32'h0, ns, rd, bad, rwd, to);
    n_cmp++;
    if (rd !== 32'h98765A44) begin n_bad++; $display("FAIL sh_lane got %h want 98765a44", rd); end
  endtask

  task automatic test_misaligned();
    int ns; logic [31:0] rd; bit bad, to; logic rwd;
    memWrite = 1; size = 2'b10; aluResult = 32'h22; writeData = 32'hFFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (mis_v[0] !== 1'b1 || stall_v[0] !== 1'b0) begin
        n_bad++; $display("FAIL mis_word_store got mis %b stall %b want 1/0", mis_v[0], stall_v[0]);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    do_access(0, 1, 0, 2'b10, 0, 32'h20, 32'h0, ns, rd, bad, rwd, to);
    n_cmp++;
    if (rd !== 32'h98765A44) begin n_bad++; $display("FAIL mis_mem_unchanged got %h want 98765a44", rd); end
    memRead = 1; size = 2'b01; aluResult = 32'h21;
    @(negedge clk);
    n_cmp++;
    if (rd_v[0] !== 32'h0 || mis_v[0] !== 1'b1 || stall_v[0] !== 1'b0) begin
      n_bad++; $display("FAIL mis_half_load got data %h mis %b stall %b want 0/1/0", rd_v[0], mis_v[0], stall_v[0]);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset_mid_access();
    int ns; logic [31:0] rd; bit bad, to; logic rwd;
    rst_v = 3'b101;
    @(posedge clk); #1;
    do_access(1, 0, 1, 2'b10, 0, 32'h30, 32'h12345678, ns, rd, bad, rwd, to);
    n_cmp++;
    if (to || ns != 3) begin n_bad++; $display("FAIL lat3_stall got %0d want 3", ns); end
    memWrite = 1; size = 2'b10; aluResult = 32'h30; writeData = 32'hCAFEF00D;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if (stall_v[1] !== 1'b1) begin n_bad++; $display("FAIL lat3_wait2_stall got %b want 1", stall_v[1]); end
    #2 rst_v[1] = 1'b1;
    #1;
    n_cmp++;
    if (stall_v[1] !== 1'b0) begin n_bad++; $display("FAIL midreset_stall got %b want 0", stall_v[1]); end
    @(posedge clk); @(posedge clk); #1;
    idle_inputs();
    rst_v[1] = 1'b0;
    @(posedge clk); #1;
    do_access(1, 1, 0, 2'b10, 0, 32'h30, 32'h0, ns, rd, bad, rwd, to);
    n_cmp++;
    if (to || ns != 3 || rd !== 32'h12345678) begin
      n_bad++; $display("FAIL midreset_load got %h stall %0d want 12345678/3", rd, ns);
    end
  endtask

  task automatic test_lat0_wrap();
    int ns; logic [31:0] rd; bit bad, to; logic rwd;
    rst_v = 3'b011;
    @(posedge clk); #1;
    do_access(2, 0, 1, 2'b10, 0, 32'h400, 32'hAABBCCDD, ns, rd, bad, rwd, to);
    n_cmp++;
    if (to || ns != 0) begin n_bad++; $display("FAIL lat0_store_stall got %0d want 0", ns); end
    do_access(2, 1, 0, 2'b10, 0, 32'h000, 32'h0, ns, rd, bad, rwd, to);
    n_cmp++;
    if (ns != 0 || rd !== 32'hAABBCCDD) begin n_bad++; $display("FAIL lat0_wrap got %h stall %0d want aabbccdd/0", rd, ns); end
    do_access(2, 1, 1, 2'b10, 0, 32'h000, 32'h01020304, ns, rd, bad, rwd, to);
    n_cmp++;
    if (rd !== 32'hAABBCCDD) begin n_bad++; $display("FAIL rw_prestore got %h want aabbccdd", rd); end
    do_access(2, 1, 0, 2'b10, 0, 32'h000, 32'h0, ns, rd, bad, rwd, to);
    n_cmp++;
    if (rd !== 32'h01020304) begin n_bad++; $display("FAIL rw_committed got %h want 01020304", rd); end
    regWrite = 1; aluResult = 32'h0BADF00D; writeReg = 5'd17;
    @(negedge clk);
    n_cmp++;
    if (alu_v[2] !== 32'h0BADF00D || wr_v[2] !== 5'd17 || rw_v[2] !== 1'b1 || stall_v[2] !== 1'b0) begin
      n_bad++; $display("FAIL alu_only got %h/%0d rw %b stall %b want 0badf00d/17/1/0",
                        alu_v[2], wr_v[2], rw_v[2], stall_v[2]);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int ns; logic [31:0] rd; bit bad, to; logic rwd;
    rst_v = 3'b110;
    @(posedge clk); #1;
    do_access(0, 0, 1, 2'b10, 0, 32'h44, 32'h55AA55AA, ns, rd, bad, rwd, to);
    do_access(0, 1, 0, 2'b10, 0, 32'h44, 32'h0, ns, rd, bad, rwd, to);
    n_cmp++;
    if (to || ns != 2 || rd !== 32'h55AA55AA) begin
      n_bad++; $display("FAIL back_to_back got %h stall %0d want 55aa55aa/2", rd, ns);
    end
  endtask

  initial begin
    idle_inputs();
    @(posedge clk); #1;
    test_reset();
    test_word_store_load();
    test_subword();
    test_byte_store();
    test_misaligned();
    test_reset_mid_access();
    test_lat0_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, between the EX/MEM pipeline register and the MEM/WB register. Performs byte/half/word loads and stores against an internal data memory with sign/zero extension and alignment checking. A programmable wait-state counter lets the stage model a slow data memory, raising `stall` to the hazard unit while an access is in progress. All outputs feed the MEM/WB register directly.

## Interface

Parameters:
- `DEPTH`, 256: data memory size in 32-bit words; power of two.
- `LATENCY`, 2: extra wait cycles per memory access; 0 gives single-cycle access.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `memRead` input 1: load request.
- `memWrite` input 1: store request.
- `regWrite` input 1: writeback enable from EX/MEM.
- `memToReg` input 1: writeback source select from EX/MEM.
- `size` input 2: 00 byte, 01 half, 10 word; 11 treated as word.
- `loadUnsigned` input 1: 1 zero-extends sub-word loads; 0 sign-extends.
- `aluResult` input 32: byte address for memory ops; passed through otherwise.
- `writeData` input 32: store data, right-aligned.
- `writeReg` input 5: destination register.
- `out_regWrite` output 1: `regWrite & ~stall & ~reset`.
- `out_memToReg` output 1: pass-through of `memToReg`.
- `out_aluResult` output 32: pass-through of `aluResult`.
- `out_readData` output 32: extended load result.
- `out_writeReg` output 5: pass-through of `writeReg`.
- `stall` output 1: freeze request to PC, IF/ID, ID/EX and EX/MEM.
- `misaligned` output 1: alignment fault for the current access.

## Operation

- **Access:** `access = (memRead | memWrite) & ~misaligned`.
- **Alignment:** `misaligned` is 1 for half with `aluResult[0]=1`, or word with `aluResult[1:0]!=0`. A misaligned access:
  - starts no transaction, raises no stall and commits no store;
  - forces `out_readData=0`.
- **Indexing:** word index is `aluResult[log2(DEPTH)+1:2]`; higher address bits are ignored (wrap-around).
- **Read path:** memory read is combinational. Byte lanes are little-endian, selected by `aluResult[1:0]` (byte) or `aluResult[1]` (half). The result is extended per `loadUnsigned`. When `memRead=0`, `out_readData=0`.
- **Stores:** write only the selected lanes. Byte writes `writeData[7:0]`, half writes `writeData[15:0]`. A store commits on the rising edge that ends the completion cycle, exactly once per access.
- **Read and write together:** if `memRead` and `memWrite` are both 1, the store is performed and `out_readData` shows the pre-store contents.
- **Control state:** FSM states IDLE and WAIT, plus a down-counter `cnt` of width `clog2(LATENCY+1)`.
  - IDLE, `access`, `LATENCY=0`: this is the completion cycle; `stall=0`; stay in IDLE.
  - IDLE, `access`, `LATENCY>0`: `stall=1`; load `cnt=LATENCY-1`; go to WAIT.
  - WAIT, `cnt!=0`: `stall=1`; decrement `cnt`.
  - WAIT, `cnt==0`: completion cycle; `stall=0`; go to IDLE.
  - IDLE, no access: `stall=0`.
- **Upstream contract:** upstream holds all inputs stable while `stall=1`. Inputs changing mid-access are not supported.
- **Back-to-back accesses:** an access presented in the cycle after a completion starts a fresh transaction.
- **Reset:**
  - Forces IDLE, `cnt=0`, `stall=0` and `out_regWrite=0`.
  - A pending store is dropped.
  - Memory contents are not cleared.

## Timing

- **Latency:** an aligned access accepted in cycle T has `stall` high in cycles T..T+LATENCY-1. Cycle T+LATENCY is the completion cycle.
- **Load data:** `out_readData` is valid in the completion cycle and is captured by MEM/WB at its end.
- **Bubble:** `out_regWrite` is 0 in every stalled cycle, so MEM/WB captures a bubble.
- **Reset values (all outputs):**
  - `stall=0`, `out_regWrite=0`.
  - `misaligned`, `out_memToReg`, `out_aluResult`, `out_writeReg` follow their inputs combinationally.
  - `out_readData` follows the combinational read (0 when `memRead=0`).
- **Mid-access reset:** asserting reset at any point in WAIT deasserts `stall` immediately (asynchronously); the store never commits.
- **Non-memory instructions:** complete with zero latency and never stall.

## Test plan

- **Word store then load (LATENCY=2):** store 0xDEADBEEF to 0x10, then load 0x10 -> `stall` high exactly 2 cycles per access; `out_readData=0xDEADBEEF` in each completion cycle; `out_regWrite` 0 while stalled.
- **Sub-word extension:** word 0x8077F0A1 at 0x20 -> byte load 0x20 signed = 0xFFFFFFA1; byte 0x23 unsigned = 0x00000080; half 0x22 signed = 0xFFFF8077; half 0x20 unsigned = 0x0000F0A1.
- **Byte store lane masking:** store byte 0x5A to 0x21 over 0x11223344 -> word reads 0x11225A44.
- **Misaligned access:** word store to 0x22 -> `misaligned=1`, `stall=0`, memory unchanged; half load at 0x21 -> `out_readData=0`.
- **Reset mid-access:** store 0xCAFEF00D to 0x30 with LATENCY=3; assert reset in the second WAIT cycle -> `stall` drops immediately and the word at 0x30 keeps its old value; a load after reset completes normally.
- **LATENCY=0 and wrap-around (DEPTH=256):** store to 0x400 then load 0x000 -> same word; `stall` never asserted; ALU-only instruction passes `aluResult`/`writeReg` through unchanged with `out_regWrite=1`.
